// File: rtl/posit_repack_8bit_pkg.sv
// posit_repack_8bit_pkg: shared posit8 constants and the unpacked-product layout
package posit_repack_8bit_pkg;

    localparam int POSIT8_EXP_BIAS = 16;
    localparam logic [7:0] POSIT8_MAXPOS = 8'h7F;
    localparam logic [7:0] POSIT8_MINPOS = 8'h01;
    localparam logic [7:0] POSIT8_NAR = 8'h80;
    localparam int MAX_SCALE = 6;

    typedef struct packed {
        logic sign;
        logic [4:0] exp;
        logic [12:0] frac;
    } posit8_prod_t;

endpackage

// File: rtl/posit_repack_8bit_round_rne.sv
// posit8_round_rne: splice regime and fraction, keep 7 bits, round to nearest even
module posit8_round_rne
    import posit_repack_8bit_pkg::*;
(
    input  logic [7:0]  regime,
    input  logic [12:0] frac,
    input  logic [3:0]  regime_len,
    output logic [6:0]  mag,
    output logic        sat
);

    logic [20:0] bits;
    logic [6:0] keep;
    logic [6:0] sum;
    logic guard;
    logic sticky;
    logic up;

    // regime is left-aligned with zeros past its length, so the fraction is ORed in behind it
    always_comb begin
        bits = {regime, 13'd0} | ({frac, 8'd0} >> regime_len);
        keep = bits[20:14];
        guard = bits[13];
        sticky = |bits[12:0];
        up = guard & (sticky | keep[0]);
        sat = up & (keep == POSIT8_MAXPOS[6:0]);
        sum = sat ? keep : keep + 7'(up);
        mag = (sum == 7'd0) ? POSIT8_MINPOS[6:0] : sum;
    end

endmodule

// File: rtl/posit_repack_8bit.sv
// posit_repack_8bit: two-stage round-and-pack of the posit8 multiplier product
module posit_repack_8bit
    import posit_repack_8bit_pkg::*;
#(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [18:0]          in_product,
    input  logic                 in_zero,
    input  logic                 in_nar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_posit,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 sat_clear
);

    posit8_prod_t prod;
    logic signed [5:0] k;
    logic signed [5:0] kc;
    logic [2:0] ka;
    logic ovf;
    logic unf;
    logic [3:0] d_rl;
    logic [7:0] d_reg;
    logic [12:0] d_frac;
    logic d_sat;

    logic s1_valid;
    logic s1_sign;
    logic s1_nar;
    logic s1_zero;
    logic s1_sat;
    logic [3:0] s1_rl;
    logic [7:0] s1_reg;
    logic [12:0] s1_frac;
    logic s1_advance;

    logic [6:0] mag;
    logic rnd_sat;
    logic [7:0] res;
    logic sat_evt;
    logic s2_valid;

    assign prod = in_product;
    assign s1_advance = !s2_valid | out_ready;
    assign in_ready = !s1_valid | s1_advance;
    assign out_valid = s2_valid;

    // out-of-range scales are folded onto the +/-MAX_SCALE regime with an empty fraction,
    // which makes the round stage produce exactly maxpos/minpos without a separate path
    always_comb begin
        k = 6'($signed({1'b0, prod.exp}) - POSIT8_EXP_BIAS);
        ovf = k > MAX_SCALE;
        unf = k < -MAX_SCALE;
        kc = ovf ? 6'(MAX_SCALE) : unf ? 6'(-MAX_SCALE) : k;
        ka = kc[5] ? 3'(-kc) : 3'(kc);
        d_rl = kc[5] ? 4'(ka) + 4'd1 : 4'(ka) + 4'd2;
        d_reg = kc[5] ? 8'h80 >> ka : ~(8'hFF >> (4'(ka) + 4'd1));
        d_frac = (ovf | unf) ? 13'd0 : prod.frac;
        d_sat = !in_nar & !in_zero & (ovf | unf);
    end

    // stage 1: capture decoded regime, fraction and special flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign <= 1'b0;
            s1_nar <= 1'b0;
            s1_zero <= 1'b0;
            s1_sat <= 1'b0;
            s1_rl <= 4'd0;
            s1_reg <= 8'd0;
            s1_frac <= 13'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_sign <= prod.sign;
            s1_nar <= in_nar;
            s1_zero <= in_zero;
            s1_sat <= d_sat;
            s1_rl <= d_rl;
            s1_reg <= d_reg;
            s1_frac <= d_frac;
        end
    end

    posit8_round_rne u_round (
        .regime     (s1_reg),
        .frac       (s1_frac),
        .regime_len (s1_rl),
        .mag        (mag),
        .sat        (rnd_sat)
    );

    // specials bypass the rounded magnitude; negative values are the two's complement
    always_comb begin
        res = s1_nar ? POSIT8_NAR : s1_zero ? 8'h00 : s1_sign ? 8'd0 - {1'b0, mag} : {1'b0, mag};
        sat_evt = s1_valid & s1_advance & !s1_nar & !s1_zero & (s1_sat | rnd_sat);
    end

    // stage 2: registered result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_posit <= 8'h00;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) out_posit <= res;
        end
    end

    // saturating debug count of clamped results; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_count <= '0;
        else if (sat_clear) sat_count <= '0;
        else if (sat_evt && !(&sat_count)) sat_count <= sat_count + 1'b1;
    end

endmodule

// File: tb/tb_posit_repack_8bit.sv
// tb_posit_repack_8bit: randomized and directed checks of the posit8 repack stage
module tb_posit_repack_8bit;

    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [18:0] in_product = 0;
    logic in_zero = 0;
    logic in_nar = 0;
    logic out_valid;
    logic out_ready = 1;
    logic [7:0] out_posit;
    logic [7:0] sat_count;
    logic sat_clear = 0;

    int n_cmp = 0;
    int n_bad = 0;

    posit_repack_8bit #(.SAT_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_zero    (in_zero),
        .in_nar     (in_nar),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .sat_count  (sat_count),
        .sat_clear  (sat_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference: build the posit bit string as a list of bits and round it
    function automatic logic [7:0] ref_posit(input logic s, input logic [4:0] e, input logic [12:0] f,
                                             input logic z, input logic n, output logic sat);
        int k;
        int mag;
        bit q[$];
        bit g;
        bit st;
        sat = 0;
        if (n) return 8'h80;
        if (z) return 8'h00;
        k = int'(e) - 16;
        if (k > 6) begin
            sat = 1;
            mag = 127;
        end else if (k < -6) begin
            sat = 1;
            mag = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 12; i >= 0; i--) q.push_back(f[i]);
            mag = 0;
            for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
            g = q[7];
            st = 0;
            for (int i = 8; i < q.size(); i++) st |= q[i];
            if (g && (st || (mag % 2 == 1))) begin
                if (mag == 127) sat = 1;
                else mag++;
            end
            if (mag == 0) mag = 1;
        end
        return s ? 8'((256 - mag) % 256) : 8'(mag);
    endfunction

    task automatic drive(input logic s, input logic [4:0] e, input logic [12:0] f, input logic z, input logic n);
        in_valid = 1;
        in_product = {s, e, f};
        in_zero = z;
        in_nar = n;
    endtask

    // send one product into an idle pipeline and wait for its result
    task automatic run_one(input logic s, input logic [4:0] e, input logic [12:0] f, input logic z,
                           input logic n, output logic [7:0] res, output int lat);
        @(negedge clk);
        drive(s, e, f, z, n);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 0;
        end while (!out_valid && lat < 10);
        res = out_posit;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_posit !== 8'h00) begin n_bad++; $display("FAIL reset_out_posit: got %h want 00", out_posit); end
        if (sat_count !== 8'h00) begin n_bad++; $display("FAIL reset_sat_count: got %h want 00", sat_count); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic s_t[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0] e_t[5] = '{5'd16, 5'd16, 5'd17, 5'd16, 5'd16};
        logic [12:0] f_t[5] = '{13'h0000, 13'h0000, 13'h1000, 13'h0080, 13'h0180};
        logic [7:0] w_t[5] = '{8'h40, 8'hC0, 8'h68, 8'h40, 8'h42};
        logic [7:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(s_t[i], e_t[i], f_t[i], 1'b0, 1'b0, res, lat);
            n_cmp += 2;
            if (res !== w_t[i]) begin n_bad++; $display("FAIL directed_%0d: got %h want %h", i, res, w_t[i]); end
            if (lat !== 2) begin n_bad++; $display("FAIL latency_%0d: got %0d want 2", i, lat); end
        end
        n_cmp++;
        if (sat_count !== 8'd0) begin n_bad++; $display("FAIL directed_sat_count: got %0d want 0", sat_count); end
    endtask

    task automatic test_saturation();
        logic [7:0] res;
        int lat;
        run_one(1'b0, 5'd31, 13'h1ABC, 1'b0, 1'b0, res, lat);
        n_cmp += 2;
        if (res !== 8'h7F) begin n_bad++; $display("FAIL clamp_max: got %h want 7f", res); end
        if (sat_count !== 8'd1) begin n_bad++; $display("FAIL sat_count_1: got %0d want 1", sat_count); end
        run_one(1'b0, 5'd0, 13'h0555, 1'b0, 1'b0, res, lat);
        n_cmp += 2;
        if (res !== 8'h01) begin n_bad++; $display("FAIL clamp_min: got %h want 01", res); end
        if (sat_count !== 8'd2) begin n_bad++; $display("FAIL sat_count_2: got %0d want 2", sat_count); end
        @(negedge clk);
        drive(1'b0, 5'd31, 13'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        sat_clear = 1;
        @(posedge clk);
        @(negedge clk);
        sat_clear = 0;
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clear_out_valid: got %b want 1", out_valid); end
        if (out_posit !== 8'h7F) begin n_bad++; $display("FAIL clear_out_posit: got %h want 7f", out_posit); end
        if (sat_count !== 8'd0) begin n_bad++; $display("FAIL clear_coincident: got %0d want 0", sat_count); end
    endtask

    task automatic test_specials();
        logic [7:0] res;
        int lat;
        run_one(1'b0, 5'd16, 13'h0, 1'b1, 1'b1, res, lat);
        n_cmp++;
        if (res !== 8'h80) begin n_bad++; $display("FAIL nar_and_zero: got %h want 80", res); end
        run_one(1'b1, 5'd31, 13'h0, 1'b1, 1'b0, res, lat);
        n_cmp++;
        if (res !== 8'h00) begin n_bad++; $display("FAIL zero_only: got %h want 00", res); end
        run_one(1'b1, 5'd0, 13'h1FFF, 1'b0, 1'b1, res, lat);
        n_cmp += 2;
        if (res !== 8'h80) begin n_bad++; $display("FAIL nar_only: got %h want 80", res); end
        if (sat_count !== 8'd0) begin n_bad++; $display("FAIL special_sat_count: got %0d want 0", sat_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        logic [7:0] held = 0;
        logic hold = 0;
        logic acc = 0;
        logic sat;
        logic s;
        logic [4:0] e;
        logic [12:0] f;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int drop_at = -1;
        while (got < 5 && cyc < 100) begin
            @(negedge clk);
            if (acc) in_valid = 0;
            out_ready = (cyc >= 3);
            if (sent < 5 && !in_valid) begin
                s = 1'($urandom);
                e = 5'($urandom_range(10, 22));
                f = 13'($urandom);
                drive(s, e, f, 1'b0, 1'b0);
                exp_q.push_back(ref_posit(s, e, f, 1'b0, 1'b0, sat));
            end
            #1;
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_posit !== held) begin
                    n_bad++;
                    $display("FAIL bp_stable: got %b/%h want 1/%h", out_valid, out_posit, held);
                end
            end
            if (in_valid && !in_ready && drop_at < 0) drop_at = sent;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_posit !== exp_q[0]) begin n_bad++; $display("FAIL bp_result_%0d: got %h want %h", got, out_posit, exp_q[0]); end
                void'(exp_q.pop_front());
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) sent++;
            hold = out_valid && !out_ready;
            held = out_posit;
            cyc++;
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 1;
        n_cmp += 2;
        if (got !== 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got); end
        if (drop_at !== 2) begin n_bad++; $display("FAIL bp_in_ready_drop: got %0d want 2", drop_at); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] held = 0;
        logic hold = 0;
        logic acc = 0;
        logic sat;
        logic s;
        logic z;
        logic n;
        logic [4:0] e;
        logic [12:0] f;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int events = 0;
        int n_items = 600;
        @(negedge clk);
        sat_clear = 1;
        @(negedge clk);
        sat_clear = 0;
        n_cmp++;
        if (sat_count !== 8'd0) begin n_bad++; $display("FAIL rand_clear: got %0d want 0", sat_count); end
        while (got < n_items && cyc < 20000) begin
            @(negedge clk);
            if (acc) in_valid = 0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < n_items && !in_valid && $urandom_range(0, 3) != 0) begin
                s = 1'($urandom);
                e = 5'($urandom_range(0, 31));
                f = 13'($urandom);
                z = ($urandom_range(0, 15) == 0);
                n = ($urandom_range(0, 15) == 0);
                drive(s, e, f, z, n);
                exp_q.push_back(ref_posit(s, e, f, z, n, sat));
                if (sat) events++;
            end
            #1;
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_posit !== held) begin
                    n_bad++;
                    $display("FAIL rand_stable: got %b/%h want 1/%h", out_valid, out_posit, held);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra: got %h want none", out_posit);
                end else begin
                    if (out_posit !== exp_q[0]) begin n_bad++; $display("FAIL rand_result_%0d: got %h want %h", got, out_posit, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) sent++;
            hold = out_valid && !out_ready;
            held = out_posit;
            cyc++;
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 1;
        n_cmp += 2;
        if (got !== n_items) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got, n_items); end
        if (sat_count !== 8'(events > 255 ? 255 : events)) begin
            n_bad++;
            $display("FAIL rand_sat_count: got %0d want %0d", sat_count, events > 255 ? 255 : events);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen = 0;
        logic [7:0] res;
        int lat;
        @(negedge clk);
        out_ready = 0;
        drive(1'b0, 5'd16, 13'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd17, 13'h0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: got %b want 1", out_valid); end
        rst_n = 0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (out_posit !== 8'h00) begin n_bad++; $display("FAIL mid_out_posit: got %h want 00", out_posit); end
        if (sat_count !== 8'h00) begin n_bad++; $display("FAIL mid_sat_count: got %h want 00", sat_count); end
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        n_cmp += 2;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got %b want 0", seen); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        run_one(1'b1, 5'd17, 13'h1000, 1'b0, 1'b0, res, lat);
        n_cmp++;
        if (res !== 8'h98) begin n_bad++; $display("FAIL mid_after: got %h want 98", res); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_specials();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
